// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer: FSM encodings, button
// indices, default screen geometry and a one-hot helper.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_MISS     = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // True when exactly one of the four direction bits is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_btn.sv
// Button front end: two-flop synchronizer, once-per-frame sample, one-hot
// direction filter and start-button rising-edge detector.
module btn_sync_onehot
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ft,
    input  logic [4:0] btn,
    output logic [4:0] press,
    output logic       start_req
);

    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] btn_s;

    // Metastability guard; runs every clk, not gated by the pixel enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 5'd0;
            sync2 <= 5'd0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // One sample per frame so the paddle sees a stable direction all frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     btn_s <= 5'd0;
        else if (ft) btn_s <= sync2;
    end

    // Chords (two directions at once) are treated as no press; the centre
    // button never reaches the paddle.
    assign press     = is_onehot4(btn_s[3:0]) ? {1'b0, btn_s[3:0]} : 5'd0;
    assign start_req = ft & sync2[BTN_C] & ~btn_s[BTN_C];

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencer: frame tick from the raster, move/serve strobes for the
// paddle and ball blocks, score and lives bookkeeping.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int FRAME_V      = 480,
    parameter int BALL_DIV     = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_Y       = 470,
    parameter int LIVES_INIT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic [4:0] btn,
    input  logic [9:0] ball_yloc,
    input  logic       paddle_hit,
    output logic [4:0] press,
    output logic       move_paddle,
    output logic       move_ball,
    output logic       ball_rst,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over
);

    localparam logic [9:0] FRAME_V_L  = 10'(FRAME_V);
    localparam logic [9:0] MISS_Y_L   = 10'(MISS_Y);
    localparam logic [3:0] DIV_LAST   = 4'(BALL_DIV - 1);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [1:0] LIVES_L    = 2'(LIVES_INIT);

    logic       ft;
    logic       start_req;
    state_t     state_q, state_n;
    logic [7:0] score_q, score_n;
    logic [1:0] lives_q, lives_n;
    logic [7:0] serve_cnt, serve_cnt_n;
    logic [3:0] ball_div, ball_div_n;
    logic       mp_n, mb_n, br_n;

    // First pixel of the first blanking line: one tick per frame.
    assign ft = pixpulse & (hcount == 10'd0) & (vcount == FRAME_V_L);

    btn_sync_onehot u_btn (
        .clk       (clk),
        .rst       (rst),
        .ft        (ft),
        .btn       (btn),
        .press     (press),
        .start_req (start_req)
    );

    // State and strobe registers advance only on pixel-enable edges so every
    // output holds for one whole pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            score_q     <= 8'd0;
            lives_q     <= LIVES_L;
            serve_cnt   <= 8'd0;
            ball_div    <= 4'd0;
            move_paddle <= 1'b0;
            move_ball   <= 1'b0;
            ball_rst    <= 1'b0;
        end else if (pixpulse) begin
            state_q     <= state_n;
            score_q     <= score_n;
            lives_q     <= lives_n;
            serve_cnt   <= serve_cnt_n;
            ball_div    <= ball_div_n;
            move_paddle <= mp_n;
            move_ball   <= mb_n;
            ball_rst    <= br_n;
        end
    end

    // Next-state, counters and strobe requests.
    always_comb begin
        state_n     = state_q;
        score_n     = score_q;
        lives_n     = lives_q;
        serve_cnt_n = serve_cnt;
        ball_div_n  = ball_div;
        mp_n        = 1'b0;
        mb_n        = 1'b0;
        br_n        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    score_n     = 8'd0;
                    lives_n     = LIVES_L;
                    serve_cnt_n = 8'd0;
                    br_n        = 1'b1;
                    state_n     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // Paddle stays live during the serve delay; the ball waits.
                if (ft) begin
                    mp_n = 1'b1;
                    if (serve_cnt == SERVE_LAST) begin
                        ball_div_n = 4'd0;
                        state_n    = ST_PLAY;
                    end else begin
                        serve_cnt_n = serve_cnt + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (paddle_hit && score_q != 8'hFF) score_n = score_q + 8'd1;
                if (ft) begin
                    mp_n = 1'b1;
                    if (ball_div == DIV_LAST) begin
                        ball_div_n = 4'd0;
                        mb_n       = 1'b1;
                    end else begin
                        ball_div_n = ball_div + 4'd1;
                    end
                    // Strobes of this tick still go out; the miss only moves the FSM.
                    if (ball_yloc >= MISS_Y_L) state_n = ST_MISS;
                end
            end
            ST_MISS: begin
                lives_n = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_n = ST_GAMEOVER;
                end else begin
                    serve_cnt_n = 8'd0;
                    br_n        = 1'b1;
                    state_n     = ST_SERVE;
                end
            end
            ST_GAMEOVER: begin
                if (start_req) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign score     = score_q;
    assign lives     = lives_q;
    assign state     = state_q;
    assign game_over = (state_q == ST_GAMEOVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus pushes expected output
// snapshots, a monitor pops one for every pixel period that carries a strobe
// or a change of state/score/lives.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    // Small raster (4 x 8 pixels) keeps a frame at 128 clk.
    localparam int         FRAME_V = 6;
    localparam logic [9:0] HMAX    = 10'd3;
    localparam logic [9:0] VMAX    = 10'd7;
    localparam logic [9:0] FT_V    = 10'(FRAME_V);

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] press;
        logic       mp;
        logic       mb;
        logic       br;
        logic [7:0] score;
        logic [1:0] lives;
        logic       go;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = 10'd0;
    logic [9:0] vcount = 10'd0;
    logic [4:0] btn = 5'd0;
    logic [9:0] ball_yloc = 10'd100;
    logic       paddle_hit = 1'b0;
    logic [4:0] press;
    logic       move_paddle, move_ball, ball_rst, game_over;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t expq[$];
    logic [4:0] e_press = 5'd0;
    logic [7:0] e_score = 8'd0;
    logic [1:0] e_lives = 2'd3;

    pong_game_ctrl #(
        .FRAME_V(FRAME_V), .BALL_DIV(2), .SERVE_FRAMES(60), .MISS_Y(470), .LIVES_INIT(3)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .btn(btn), .ball_yloc(ball_yloc), .paddle_hit(paddle_hit), .press(press),
        .move_paddle(move_paddle), .move_ball(move_ball), .ball_rst(ball_rst),
        .score(score), .lives(lives), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Raster source: pixpulse one clk in four, h/v advance after each pixel.
    initial begin : raster
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt = (cnt + 1) % 4;
            pixpulse = (cnt == 0);
            if (cnt == 1) begin
                if (hcount == HMAX) begin
                    hcount = 10'd0;
                    vcount = (vcount == VMAX) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount = hcount + 10'd1;
                end
            end
        end
    end

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.press = press; o.mp = move_paddle; o.mb = move_ball;
        o.br = ball_rst; o.score = score; o.lives = lives; o.go = game_over;
        return o;
    endfunction

    task automatic push(input logic [2:0] st, input logic mp, input logic mb, input logic br);
        obs_t o;
        o.st = st; o.press = e_press; o.mp = mp; o.mb = mb; o.br = br;
        o.score = e_score; o.lives = e_lives; o.go = (st == ST_GAMEOVER);
        expq.push_back(o);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Returns on the pixpulse edge that samples raster position (h,v).
    task automatic wait_pix(input logic [9:0] h, input logic [9:0] v);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            if (pixpulse && hcount == h && vcount == v) return;
            n++;
            if (n >= 2000) begin
                n_cmp++; n_bad++;
                $display("FAIL timeout waiting for pixel %0d,%0d", h, v);
                return;
            end
        end
    endtask

    task automatic wait_ft();
        wait_pix(10'd0, FT_V);
    endtask

    task automatic wait_pp();
        do @(posedge clk); while (!pixpulse);
    endtask

    // One frame tick in PLAY (or the tick that detects a miss).
    task automatic play_tick(input logic [2:0] st_after, input logic mb);
        push(st_after, 1'b1, mb, 1'b0);
        wait_ft();
    endtask

    // 60 ticks of serve; the last one enters PLAY.
    task automatic serve_phase();
        for (int i = 1; i < 60; i++) begin
            push(ST_SERVE, 1'b1, 1'b0, 1'b0);
            wait_ft();
        end
        push(ST_PLAY, 1'b1, 1'b0, 1'b0);
        wait_ft();
    endtask

    // One-pixel paddle_hit pulse followed by an idle pixel.
    task automatic hit();
        if (e_score != 8'd255) begin
            e_score = e_score + 8'd1;
            push(ST_PLAY, 1'b0, 1'b0, 1'b0);
        end
        #1 paddle_hit = 1'b1;
        wait_pp();
        #1 paddle_hit = 1'b0;
        wait_pp();
    endtask

    // Monitor: one snapshot per pixel period, compared when anything happens.
    initial begin : monitor
        obs_t cur, last, e;
        last = '0;
        forever begin
            @(posedge clk);
            if (pixpulse) begin
                #1;
                cur = sample();
                if (rst) begin
                    last = cur;
                end else if (cur.mp || cur.mb || cur.br || cur.st != last.st ||
                             cur.score != last.score || cur.lives != last.lives ||
                             cur.go != last.go) begin
                    n_cmp++;
                    if (expq.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected event: st=%0d press=%b mp=%b mb=%b br=%b score=%0d lives=%0d go=%b",
                                 cur.st, cur.press, cur.mp, cur.mb, cur.br, cur.score, cur.lives, cur.go);
                    end else begin
                        e = expq.pop_front();
                        if (cur !== e) begin
                            n_bad++;
                            $display("FAIL event %0d: got st=%0d press=%b mp=%b mb=%b br=%b score=%0d lives=%0d go=%b, want st=%0d press=%b mp=%b mb=%b br=%b score=%0d lives=%0d go=%b",
                                     n_cmp, cur.st, cur.press, cur.mp, cur.mb, cur.br, cur.score, cur.lives, cur.go,
                                     e.st, e.press, e.mp, e.mb, e.br, e.score, e.lives, e.go);
                        end
                    end
                    last = cur;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        chk({tag, "_press"}, 32'(press), 32'd0);
        chk({tag, "_move_paddle"}, 32'(move_paddle), 32'd0);
        chk({tag, "_move_ball"}, 32'(move_ball), 32'd0);
        chk({tag, "_ball_rst"}, 32'(ball_rst), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin : stim
        logic mbt;
        repeat (10) @(posedge clk);
        #1 chk_reset("reset");
        rst = 1'b0;

        // Start: btn[4] held across one frame -> SERVE with a one-pixel ball_rst.
        wait_ft();
        #1 btn = 5'b10000;
        push(ST_SERVE, 1'b0, 1'b0, 1'b1);
        wait_ft();
        #1 btn = 5'b00000;
        serve_phase();

        // Single direction held: press follows, ball moves every second tick.
        #1 btn = 5'b00010;
        e_press = 5'b00010;
        play_tick(ST_PLAY, 1'b0);
        play_tick(ST_PLAY, 1'b1);
        play_tick(ST_PLAY, 1'b0);
        play_tick(ST_PLAY, 1'b1);

        // Two directions at once: no press, paddle strobe still issued.
        #1 btn = 5'b00011;
        e_press = 5'b00000;
        play_tick(ST_PLAY, 1'b0);
        play_tick(ST_PLAY, 1'b1);
        #1 btn = 5'b00000;

        // Three hits.
        repeat (3) hit();
        chk("score_after_3_hits", 32'(score), 32'd3);

        // Miss with a hit on the same pixel: score counts, miss wins.
        #1 ball_yloc = 10'd470;
        wait_pix(HMAX, FT_V - 10'd1);
        #1 paddle_hit = 1'b1;
        e_score = 8'd4;
        push(ST_MISS, 1'b1, 1'b0, 1'b0);
        wait_ft();
        e_lives = 2'd2;
        push(ST_SERVE, 1'b0, 1'b0, 1'b1);
        #1 paddle_hit = 1'b0;
        ball_yloc = 10'd100;
        serve_phase();

        // Drive score to 255, then keep hitting: it must hold at 255.
        mbt = 1'b0;
        for (int f = 0; f < 26; f++) begin
            repeat (10) hit();
            play_tick(ST_PLAY, mbt);
            mbt = ~mbt;
        end
        chk("score_saturated", 32'(score), 32'd255);

        // Second miss -> SERVE with 1 life left.
        #1 ball_yloc = 10'd470;
        push(ST_MISS, 1'b1, 1'b0, 1'b0);
        wait_ft();
        e_lives = 2'd1;
        push(ST_SERVE, 1'b0, 1'b0, 1'b1);
        serve_phase();

        // Third miss -> GAMEOVER.
        push(ST_MISS, 1'b1, 1'b0, 1'b0);
        wait_ft();
        e_lives = 2'd0;
        push(ST_GAMEOVER, 1'b0, 1'b0, 1'b0);
        #1 ball_yloc = 10'd100;
        btn = 5'b10000;
        wait_pp();
        #1 chk("game_over_flag", 32'(game_over), 32'd1);

        // Start from GAMEOVER -> IDLE; score and lives stay frozen.
        push(ST_IDLE, 1'b0, 1'b0, 1'b0);
        wait_ft();
        #1 btn = 5'b00000;
        wait_ft();
        #1 btn = 5'b10000;
        e_score = 8'd0;
        e_lives = 2'd3;
        push(ST_SERVE, 1'b0, 1'b0, 1'b1);
        wait_ft();
        #1 btn = 5'b00000;
        serve_phase();
        play_tick(ST_PLAY, 1'b0);

        // Async reset while move_paddle is high.
        #2 rst = 1'b1;
        #1 chk_reset("midgame_reset");
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) wait_ft();
        repeat (8) @(posedge clk);
        chk("leftover_expected_events", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
